rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001: Parameter DATA_W, default 8, width of each requester's data bus and of the output bus.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004: in0_valid  input  1  requester 0 has a beat on in0_data.
REQ-005: in0_data  input  DATA_W  requester 0 beat payload.
REQ-006: in0_last  input  1  beat on in0_data ends requester 0's burst.
REQ-007: in0_ready  output  1  arbiter accepts requester 0 beat this cycle.
REQ-008: in1_valid, in1_data, in1_last, in1_ready  same as REQ-004..007, for requester 1.
REQ-009: out_valid  output  1  registered beat present on out_data.
REQ-010: out_data  output  DATA_W  registered muxed payload.
REQ-011: out_last  output  1  registered copy of accepted beat's last flag.
REQ-012: out_sel  output  1  index of requester that supplied the current out beat; mux select.
REQ-013: out_ready  input  1  downstream consumes the out beat when out_valid=1.

Function
REQ-014: FSM states IDLE, OWN0, OWN1; OWNk means requester k holds the channel until its last beat is accepted.
REQ-015: IDLE: no ready asserted; next state OWN0 if only in0_valid, OWN1 if only in1_valid, both valid -> state opposite the previous owner (rr_ptr); neither -> IDLE.
REQ-016: In OWNk, ink_ready = ~out_valid | out_ready; the other requester's ready is 0.
REQ-017: Accept = ink_valid & ink_ready; on accept, next cycle out_valid=1, out_data=ink_data, out_last=ink_last, out_sel=k (1-cycle latency).
REQ-018: out_valid=1 with out_ready=0 holds out_data/out_last/out_sel stable; no beat dropped or overwritten.
REQ-019: out_valid=1, out_ready=1, no accept -> out_valid=0 next cycle.
REQ-020: Simultaneous drain and accept in same cycle -> out register loads new beat, out_valid stays 1 (full throughput, one beat/cycle).
REQ-021: Accept with ink_last=0 -> stay OWNk; grant not preempted by other requester's valid.
REQ-022: Accept with ink_last=1 -> next state OWN(other) if other valid, else OWNk if ink_valid still... evaluated on current-cycle ink_valid is not used; next state IDLE if other not valid; rr_ptr updated to k.
REQ-023: ink_valid deasserted mid-burst -> stay OWNk, wait indefinitely.
REQ-024: ready is combinational from state, out_valid, out_ready only; never depends on ink_valid.

Reset
REQ-025: rst_n=0 at a rising edge -> state IDLE, rr_ptr=1 (requester 0 wins first tie), out_valid=0, out_data=0, out_last=0, out_sel=0.
REQ-026: in0_ready=in1_ready=0 during reset and in the cycle following release.
REQ-027: Reset mid-burst discards the held out beat and the ownership; no beat emitted afterward from the aborted burst unless re-presented.

Structure
REQ-028: Shared package rr_mux_pkg holds the FSM state enum (IDLE/OWN0/OWN1) and DATA_W default.
REQ-029: Next-owner selection (two valids + rr_ptr -> grant index/none) is a sub-module rr2_grant; data selection uses a 2:1 mux driven by the grant index.

Verification
REQ-030: Reset, in0_valid=1 data 0xA5 last=1, out_ready=1 -> IDLE->OWN0, one cycle later out_valid=1, out_data=0xA5, out_sel=0, out_last=1.
REQ-031: Both valid from reset, each single-beat last=1 repeatedly, out_ready=1 -> out_sel sequence 0,1,0,1..., one beat per cycle after first grant.
REQ-032: Requester 1 burst 0x10,0x11,0x12 (last on 0x12) while in0_valid=1 throughout -> three out beats out_sel=1 contiguous, then out_sel=0.
REQ-033: out_ready=0 for 3 cycles with out beat 0x3C held -> out_data stays 0x3C, in0_ready=in1_ready=0, no data lost after out_ready returns.
REQ-034: rst_n=0 in middle of 4-beat burst from requester 0 -> next cycle out_valid=0, state IDLE; new request from requester 1 served next.
REQ-035: Requester 0 drops valid for 2 cycles mid-burst while in1_valid=1 -> no out_sel=1 beat until requester 0's last beat accepted.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared types for the two-requester round-robin burst mux: FSM state encoding,
// default bus width and a small decode helper.
package rr_mux_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // Index of the requester that holds the channel in an OWN state.
  function automatic logic owner_idx(input state_e st);
    return (st == ST_OWN1);
  endfunction

endpackage

// File: rtl/rr2_grant.sv
// Two-way round-robin grant: picks the next channel owner from the two valids
// and the index of the previous owner.
module rr2_grant (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic rr_ptr_i,
  output logic gnt_valid_o,
  output logic gnt_idx_o
);

  // On a tie the requester that did not own the channel last wins.
  always_comb begin
    gnt_valid_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) begin
      gnt_idx_o = ~rr_ptr_i;
    end else if (valid1_i) begin
      gnt_idx_o = 1'b1;
    end else begin
      gnt_idx_o = 1'b0;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Burst-granular round-robin arbiter muxing two valid/ready streams onto one
// registered output stage with full one-beat-per-cycle throughput.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel,
  input  logic              out_ready
);

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              out_sel_q, out_sel_d;

  logic              gnt_valid_s;
  logic              gnt_idx_s;
  logic              own_idx_s;
  logic              ready_s;
  logic              sel_valid_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_last_s;
  logic              other_valid_s;
  logic              accept_s;

  rr2_grant u_grant (
    .valid0_i    (in0_valid),
    .valid1_i    (in1_valid),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_valid_o (gnt_valid_s),
    .gnt_idx_o   (gnt_idx_s)
  );

  // Ready depends only on ownership and output-stage occupancy, never on valid.
  always_comb begin
    own_idx_s     = owner_idx(state_q);
    ready_s       = (state_q != ST_IDLE) & (~out_valid_q | out_ready);
    in0_ready     = ready_s & ~own_idx_s;
    in1_ready     = ready_s & own_idx_s;
    sel_valid_s   = own_idx_s ? in1_valid : in0_valid;
    sel_data_s    = own_idx_s ? in1_data  : in0_data;
    sel_last_s    = own_idx_s ? in1_last  : in0_last;
    other_valid_s = own_idx_s ? in0_valid : in1_valid;
    accept_s      = ready_s & sel_valid_s;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_s && gnt_idx_s) begin
          state_d = ST_OWN1;
        end else if (gnt_valid_s) begin
          state_d = ST_OWN0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN0, ST_OWN1: begin
        // A burst only ends on an accepted last beat; the other side is then
        // handed the channel directly if it is already waiting.
        if (accept_s && sel_last_s) begin
          rr_ptr_d = own_idx_s;
          if (other_valid_s && own_idx_s) begin
            state_d = ST_OWN0;
          end else if (other_valid_s) begin
            state_d = ST_OWN1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_s;
      out_last_d  = sel_last_s;
      out_sel_d   = own_idx_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter with hand-computed expectations.
module tb_rr_mux_arbiter;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in0_valid, in0_last, in0_ready;
  logic [DW-1:0] in0_data;
  logic          in1_valid, in1_last, in1_ready;
  logic [DW-1:0] in1_data;
  logic          out_valid, out_last, out_sel, out_ready;
  logic [DW-1:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  rr_mux_arbiter #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [DW-1:0] d, input logic l);
    in0_valid = v;
    in0_data  = d;
    in0_last  = l;
  endtask

  task automatic set1(input logic v, input logic [DW-1:0] d, input logic l);
    in1_valid = v;
    in1_data  = d;
    in1_last  = l;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    set0(1'b0, 8'h00, 1'b0);
    set1(1'b0, 8'h00, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic l, input logic s);
    check_val({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    if (v) begin
      check_val({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
      check_val({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
      check_val({tag, "_sel"},  {31'd0, out_sel},  {31'd0, s});
    end
  endtask

  initial begin
    // Reset values, readies held low through reset and the release cycle, single beat.
    rst_n     = 1'b0;
    out_ready = 1'b1;
    set0(1'b1, 8'hA5, 1'b1);
    set1(1'b0, 8'h00, 1'b0);
    cyc();
    cyc();
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_out_data",  {24'd0, out_data},  32'd0);
    check_val("rst_out_last",  {31'd0, out_last},  32'd0);
    check_val("rst_out_sel",   {31'd0, out_sel},   32'd0);
    check_val("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
    check_val("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("rel_in0_ready", {31'd0, in0_ready}, 32'd0);
    cyc();
    check_val("own0_in0_ready", {31'd0, in0_ready}, 32'd1);
    check_val("own0_in1_ready", {31'd0, in1_ready}, 32'd0);
    check_val("own0_out_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    set0(1'b0, 8'h00, 1'b0);
    check_out("single", 1'b1, 8'hA5, 1'b1, 1'b0);
    cyc();
    check_out("single_drain", 1'b0, 8'h00, 1'b0, 1'b0);

    // Alternating single-beat bursts from both requesters.
    do_reset();
    set0(1'b1, 8'h20, 1'b1);
    set1(1'b1, 8'h40, 1'b1);
    cyc();
    check_out("rr_first", 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      if ((i % 2) == 0) check_out($sformatf("rr%0d", i), 1'b1, 8'h20, 1'b1, 1'b0);
      else              check_out($sformatf("rr%0d", i), 1'b1, 8'h40, 1'b1, 1'b1);
    end

    // Requester 1 burst is not preempted by a waiting requester 0.
    do_reset();
    set1(1'b1, 8'h10, 1'b0);
    cyc();
    set0(1'b1, 8'h77, 1'b1);
    #1;
    check_val("burst1_in0_ready", {31'd0, in0_ready}, 32'd0);
    check_val("burst1_in1_ready", {31'd0, in1_ready}, 32'd1);
    cyc();
    check_out("b1_0", 1'b1, 8'h10, 1'b0, 1'b1);
    set1(1'b1, 8'h11, 1'b0);
    cyc();
    check_out("b1_1", 1'b1, 8'h11, 1'b0, 1'b1);
    set1(1'b1, 8'h12, 1'b1);
    cyc();
    check_out("b1_2", 1'b1, 8'h12, 1'b1, 1'b1);
    set1(1'b0, 8'h00, 1'b0);
    cyc();
    check_out("b1_next0", 1'b1, 8'h77, 1'b1, 1'b0);

    // Backpressure holds the output beat, then drain and accept in one cycle.
    do_reset();
    set0(1'b1, 8'h3C, 1'b0);
    cyc();
    cyc();
    check_out("hold_load", 1'b1, 8'h3C, 1'b0, 1'b0);
    out_ready = 1'b0;
    set0(1'b1, 8'h3D, 1'b1);
    set1(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("hold%0d_in0_ready", i), {31'd0, in0_ready}, 32'd0);
      check_val($sformatf("hold%0d_in1_ready", i), {31'd0, in1_ready}, 32'd0);
      cyc();
      check_out($sformatf("hold%0d", i), 1'b1, 8'h3C, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check_val("resume_in0_ready", {31'd0, in0_ready}, 32'd1);
    cyc();
    check_out("resume", 1'b1, 8'h3D, 1'b1, 1'b0);
    set0(1'b0, 8'h00, 1'b0);
    cyc();
    check_out("resume_next1", 1'b1, 8'h55, 1'b1, 1'b1);
    set1(1'b0, 8'h00, 1'b0);
    cyc();
    check_out("resume_drain", 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset in the middle of a 4-beat burst from requester 0.
    do_reset();
    set0(1'b1, 8'h50, 1'b0);
    cyc();
    cyc();
    check_out("mid_b0", 1'b1, 8'h50, 1'b0, 1'b0);
    set0(1'b1, 8'h51, 1'b0);
    cyc();
    check_out("mid_b1", 1'b1, 8'h51, 1'b0, 1'b0);
    rst_n = 1'b0;
    set0(1'b0, 8'h00, 1'b0);
    set1(1'b1, 8'h99, 1'b1);
    cyc();
    check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("midrst_out_data",  {24'd0, out_data},  32'd0);
    check_val("midrst_in1_ready", {31'd0, in1_ready}, 32'd0);
    rst_n = 1'b1;
    cyc();
    check_val("midrst_own1_ready", {31'd0, in1_ready}, 32'd1);
    check_out("midrst_idle_out", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc();
    check_out("midrst_req1", 1'b1, 8'h99, 1'b1, 1'b1);
    set1(1'b0, 8'h00, 1'b0);

    // Requester 0 stalls mid-burst; requester 1 must keep waiting.
    do_reset();
    set0(1'b1, 8'h60, 1'b0);
    set1(1'b1, 8'hAA, 1'b1);
    cyc();
    cyc();
    check_out("stall_b0", 1'b1, 8'h60, 1'b0, 1'b0);
    set0(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_out($sformatf("stall%0d", i), 1'b0, 8'h00, 1'b0, 1'b0);
      check_val($sformatf("stall%0d_in1_ready", i), {31'd0, in1_ready}, 32'd0);
    end
    set0(1'b1, 8'h61, 1'b1);
    cyc();
    check_out("stall_last", 1'b1, 8'h61, 1'b1, 1'b0);
    set0(1'b0, 8'h00, 1'b0);
    cyc();
    check_out("stall_then1", 1'b1, 8'hAA, 1'b1, 1'b1);
    set1(1'b0, 8'h00, 1'b0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
